instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the instruction decoder.
- Keeps the PC and issues word-aligned reads to instruction memory over a req/gnt/rvalid interface.
- Buffers returned words in a small in-order FIFO and presents them with their PC on a valid/ready handshake to the decoder.
- Handles redirects (branch/jump) by flushing the buffer and discarding responses still in flight.

---
 rtl/instr_fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, credit-limited imem requests and in-order instruction buffer
// Optional: FETCH_MISALIGN_CHECK_EN adds a sticky fetch_misaligned flag that halts fetch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]   out_q, out_d;
  logic [CNT_W-1:0]   disc_q, disc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               hold_q, hold_d;
  logic [31:0]        mem_word_q [FIFO_DEPTH];
  logic [31:0]        mem_pc_q   [FIFO_DEPTH];

  logic               req_hs, deq, push, pop, drop, credit, halt, mis_hit;
  logic [CNT_W:0]     occ;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign halt             = misalign_q;
  assign mis_hit          = redirect & (redirect_pc[1:0] != 2'b00);
  assign fetch_misaligned = misalign_q;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign halt          = 1'b0;
  assign mis_hit       = 1'b0;
`endif

  assign instr_valid = (cnt_q != '0);
  assign instr_out   = instr_valid ? mem_word_q[rd_ptr_q] : 32'h0;
  assign instr_pc    = instr_valid ? mem_pc_q[rd_ptr_q]   : 32'h0;
  assign imem_addr   = pc_q;

  // A same-cycle pop frees a slot for good, so it may count toward credit; hold_q keeps
  // the request up if that pop was the only reason it was issued.
  assign deq      = instr_valid & instr_ready;
  assign occ      = {1'b0, out_q} + {1'b0, cnt_q} - (CNT_W+1)'(deq);
  assign credit   = occ < (CNT_W+1)'(FIFO_DEPTH);
  assign imem_req = (state_q == S_FETCH) & fetch_en & ~halt & (credit | hold_q);
  assign req_hs   = imem_req & imem_gnt;

  assign drop = imem_rvalid & (disc_q != '0);
  assign push = imem_rvalid & (disc_q == '0) & ~redirect;
  assign pop  = deq & ~redirect;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    disc_d   = disc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hold_d   = imem_req & ~imem_gnt & ~redirect;
    out_d    = out_q + CNT_W'(req_hs) - CNT_W'(imem_rvalid);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif

    if (req_hs) pc_d = pc_q + 32'd4;
    if (drop)   disc_d = disc_q - CNT_W'(1);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      rsp_pc_d = rsp_pc_q + 32'd4;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case (state_q)
      S_IDLE:  if (fetch_en && !halt) state_d = S_FETCH;
      S_FETCH: begin
        if (redirect)       state_d = (out_d != '0) ? S_FLUSH : S_FETCH;
        else if (!fetch_en) state_d = S_IDLE;
      end
      S_FLUSH: if (!redirect && disc_d == '0) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase

    // Everything still in flight after this cycle is stale once the PC jumps.
    if (redirect) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      rsp_pc_d = {redirect_pc[31:2], 2'b00};
      disc_d   = out_d;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end

    if (mis_hit) begin
      state_d = S_IDLE;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      disc_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hold_q   <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      disc_q   <= disc_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hold_q   <= hold_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_word_q[wr_ptr_q] <= imem_rdata;
      mem_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic        rsp_hold = 1'b0;
  logic [31:0] pend [$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .instr_pc(instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // In-order memory: answers one cycle after grant unless rsp_hold is set.
  always @(negedge clk) begin
    if (!rst_n) pend.delete();
    else if (imem_req && imem_gnt) pend.push_back(imem_addr);
  end

  always @(posedge clk) begin
    #2;
    if (rst_n && !rsp_hold && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    instr_ready = 1'b1; imem_gnt = 1'b1; rsp_hold = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0 ||
        instr_out !== 32'h0 || instr_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: req=%b valid=%b addr=%h out=%h pc=%h expected 0 0 0 0 0",
               imem_req, instr_valid, imem_addr, instr_out, instr_pc);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    n_tests++;
    if (fetch_misaligned !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_misaligned: got %b expected 0", fetch_misaligned);
    end
`endif
    do_reset();
    fetch_en = 1'b1;
    instr_ready = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
    end
    n_tests++;
    if (instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prefill_valid: got %b expected 1", instr_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h0 || instr_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: req=%b valid=%b addr=%h pc=%h expected 0 0 0 0",
               imem_req, instr_valid, imem_addr, instr_pc);
    end
  endtask

  task automatic test_stream();
    do_reset();
    fetch_en = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      n_tests++;
      if (imem_req !== logic'(c >= 1) || (c >= 1 && imem_addr !== 32'(4 * (c - 1)))) begin
        n_fail++;
        $display("FAIL stream_req c%0d: req=%b addr=%h expected req=%b addr=%h",
                 c, imem_req, imem_addr, logic'(c >= 1), 32'(4 * (c - 1)));
      end
      n_tests++;
      if (instr_valid !== logic'(c >= 3)) begin
        n_fail++;
        $display("FAIL stream_valid c%0d: got %b expected %b", c, instr_valid, logic'(c >= 3));
      end
      if (c >= 3) begin
        n_tests++;
        if (instr_pc !== 32'(4 * (c - 3)) || instr_out !== word_at(32'(4 * (c - 3)))) begin
          n_fail++;
          $display("FAIL stream_data c%0d: pc=%h word=%h expected pc=%h word=%h", c,
                   instr_pc, instr_out, 32'(4 * (c - 3)), word_at(32'(4 * (c - 3))));
        end
      end
    end
  endtask

  task automatic test_stall();
    int grants = 0;
    do_reset();
    fetch_en = 1'b1;
    instr_ready = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      if (imem_req && imem_gnt) grants++;
    end
    n_tests++;
    if (grants !== 2 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_credit: grants=%0d req=%b expected grants=2 req=0", grants, imem_req);
    end
    n_tests++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL stall_head: valid=%b pc=%h expected 1 00000000", instr_valid, instr_pc);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      instr_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instr_out !== word_at(32'(4 * k))) begin
        n_fail++;
        $display("FAIL stall_drain k%0d: valid=%b pc=%h word=%h expected 1 %h %h", k,
                 instr_valid, instr_pc, instr_out, 32'(4 * k), word_at(32'(4 * k)));
      end
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    fetch_en = 1'b1;
    rsp_hold = 1'b1;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) next_cycle();
      redirect = (c == 4);
      redirect_pc = 32'h100;
      if (c == 5) rsp_hold = 1'b0;
      @(negedge clk);
      if (c == 3 || c == 5 || c == 6) begin
        n_tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_quiet c%0d: req=%b valid=%b expected 0 0", c, imem_req, instr_valid);
        end
      end
      if (c == 7) begin
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
          n_fail++;
          $display("FAIL flush_refetch: req=%b addr=%h expected 1 00000100", imem_req, imem_addr);
        end
      end
      if (c == 9) begin
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_out !== word_at(32'h100)) begin
          n_fail++;
          $display("FAIL flush_first: valid=%b pc=%h word=%h expected 1 00000100 %h",
                   instr_valid, instr_pc, instr_out, word_at(32'h100));
        end
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    fetch_en = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) next_cycle();
      redirect = (c == 2);
      redirect_pc = 32'h200;
      @(negedge clk);
      if (c == 2) begin
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
          n_fail++;
          $display("FAIL same_grant: req=%b addr=%h expected 1 00000004", imem_req, imem_addr);
        end
      end
      if (c == 3 || c == 5) begin
        n_tests++;
        if (instr_valid !== 1'b0 || (c == 3 && imem_req !== 1'b0)) begin
          n_fail++;
          $display("FAIL same_stale c%0d: valid=%b req=%b expected valid 0", c, instr_valid, imem_req);
        end
      end
      if (c == 4) begin
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL same_refetch: req=%b addr=%h valid=%b expected 1 00000200 0",
                   imem_req, imem_addr, instr_valid);
        end
      end
      if (c == 6) begin
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr_out !== word_at(32'h200)) begin
          n_fail++;
          $display("FAIL same_first: valid=%b pc=%h word=%h expected 1 00000200 %h",
                   instr_valid, instr_pc, instr_out, word_at(32'h200));
        end
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [2];
    exp_pc[0] = 32'hFFFF_FFFC;
    exp_pc[1] = 32'h0000_0000;
    do_reset();
    fetch_en = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) next_cycle();
      redirect = (c == 0);
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      if (c == 1 || c == 2) begin
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== exp_pc[c-1]) begin
          n_fail++;
          $display("FAIL wrap_addr c%0d: req=%b addr=%h expected 1 %h", c, imem_req, imem_addr, exp_pc[c-1]);
        end
      end
      if (c == 3 || c == 4) begin
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== exp_pc[c-3] || instr_out !== word_at(exp_pc[c-3])) begin
          n_fail++;
          $display("FAIL wrap_data c%0d: valid=%b pc=%h word=%h expected 1 %h %h", c,
                   instr_valid, instr_pc, instr_out, exp_pc[c-3], word_at(exp_pc[c-3]));
        end
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_misalign();
    do_reset();
    fetch_en = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) next_cycle();
      redirect = (c == 0);
      redirect_pc = 32'h102;
      @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
      n_tests++;
      if (fetch_misaligned !== logic'(c >= 1) || (c >= 1 && (imem_req !== 1'b0 || instr_valid !== 1'b0))) begin
        n_fail++;
        $display("FAIL misalign c%0d: flag=%b req=%b valid=%b expected flag=%b req 0 valid 0",
                 c, fetch_misaligned, imem_req, instr_valid, logic'(c >= 1));
      end
`else
      if (c == 1) begin
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
          n_fail++;
          $display("FAIL misalign_addr: req=%b addr=%h expected 1 00000100", imem_req, imem_addr);
        end
      end
      if (c == 3) begin
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_out !== word_at(32'h100)) begin
          n_fail++;
          $display("FAIL misalign_data: valid=%b pc=%h word=%h expected 1 00000100 %h",
                   instr_valid, instr_pc, instr_out, word_at(32'h100));
        end
      end
`endif
    end
    redirect = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_redirect_same_cycle();
    test_wrap();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
